// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared state encoding and sizing helpers for the bit-serial add/sub unit
package serial_addsub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DEFAULT_WIDTH = 4;
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction
endpackage

// File: rtl/serial_addsub_fa_slice.sv
// fa_slice: single-bit combinational full adder reused once per clock by the serial datapath
module fa_slice (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/subtract, one bit per clock, start/busy/done handshake
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result
);
    localparam int CW = cnt_width(WIDTH);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry, r_sub;
    logic             w_s, w_co, w_accept, w_last;

    fa_slice u_fa (.a(r_a[0]), .b(r_b[0]), .ci(r_carry), .s(w_s), .co(w_co));

    assign w_accept = (r_state != RUN) && start;
    assign w_last   = r_cnt == CW'(WIDTH - 1);

    always_comb begin
        w_next = w_accept ? RUN : (r_state == RUN) ? (w_last ? DONE : RUN) : IDLE;
        busy   = r_state == RUN;
        done   = r_state == DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Subtract is a + ~b + ~cin; the final carry is inverted into a borrow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            result  <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_sub   <= sub;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_carry <= w_co;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) result <= {w_co ^ r_sub, w_s, r_sum[WIDTH-1:1]};
        end
    end
endmodule
